data_memory_pipe: RTL and testbench

DATA_MEMORY_PIPE -- requirements
Module: data_memory_pipe

---
 rtl/data_memory_pkg.sv | 27 ++
 rtl/data_memory_align.sv | 45 ++++
 rtl/data_memory_pipe.sv | 162 ++++++++++++++++
 tb/tb_data_memory_pipe.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// Shared encodings, FSM state type and access-classification helpers for the
// pipelined data memory.
package data_memory_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } state_t;

  // size is funct3[1:0]; true when the access spills into the next word
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == 2'b01) && (off == 2'b11)) || ((size == 2'b10) && (off != 2'b00));
  endfunction

  function automatic logic is_illegal(input logic write, input logic [2:0] ctrl);
    if (write) return (ctrl[1:0] == 2'b11);
    return !((ctrl == F3_B) || (ctrl == F3_H) || (ctrl == F3_W) ||
             (ctrl == F3_BU) || (ctrl == F3_HU));
  endfunction

endpackage

// File: rtl/data_memory_align.sv
// Combinational byte steering: store lane mask/data over a two-word window and
// load extraction with sign/zero extension.
module data_memory_align
  import data_memory_pkg::*;
(
  input  logic [1:0]  i_wr_off,
  input  logic [1:0]  i_wr_size,
  input  logic [31:0] i_wr_data,
  output logic [7:0]  o_wr_mask,
  output logic [63:0] o_wr_data,
  input  logic [63:0] i_rd_window,
  input  logic [1:0]  i_rd_off,
  input  logic [2:0]  i_rd_ctrl,
  output logic [31:0] o_rd_data
);

  logic [7:0]  w_size_mask;
  logic [31:0] w_sh;

  always_comb begin
    w_size_mask = 8'h00;
    case (i_wr_size)
      2'b00:   w_size_mask = 8'h01;
      2'b01:   w_size_mask = 8'h03;
      2'b10:   w_size_mask = 8'h0F;
      default: w_size_mask = 8'h00;
    endcase
    o_wr_mask = w_size_mask << i_wr_off;
    o_wr_data = {32'h0, i_wr_data} << {i_wr_off, 3'b000};
  end

  always_comb begin
    w_sh      = 32'(i_rd_window >> {i_rd_off, 3'b000});
    o_rd_data = 32'h0;
    case (i_rd_ctrl)
      F3_B:    o_rd_data = {{24{w_sh[7]}}, w_sh[7:0]};
      F3_H:    o_rd_data = {{16{w_sh[15]}}, w_sh[15:0]};
      F3_W:    o_rd_data = w_sh;
      F3_BU:   o_rd_data = {24'h0, w_sh[7:0]};
      F3_HU:   o_rd_data = {16'h0, w_sh[15:0]};
      default: o_rd_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/data_memory_pipe.sv
// Byte-enabled single-port data memory with a fixed-latency response pipeline;
// word-crossing accesses take a second beat through the SPLIT state.
module data_memory_pipe
  import data_memory_pkg::*;
#(
  parameter int ADDR_WIDTH   = 12,
  parameter int FILE_LOAD    = 0,
  parameter     FILE         = "",
  parameter int READ_LATENCY = 1,
  parameter int MISALIGN_EN  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [2:0]            req_ctrl_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  output state_t                dbg_state_o
);

  localparam int WA    = ADDR_WIDTH - 2;
  localparam int DEPTH = 2 ** WA;

  // Handshake: a request is taken on a rising edge where req_valid_i and
  // req_ready_o are both high; responses have no backpressure.
  state_t          r_state, w_state_nxt;
  logic [31:0]     r_mem [DEPTH];
  logic [31:0]     r_rdata, r_lo, r_wdata;
  logic [WA-1:0]   r_word;
  logic [1:0]      r_off;
  logic [2:0]      r_ctrl;
  logic            r_write, r_err, r_split, r_s1_valid;

  logic            w_accept, w_illegal, w_mis, w_err, w_split;
  logic [WA-1:0]   w_mem_addr;
  logic [3:0]      w_mem_be;
  logic [31:0]     w_mem_wdata, w_rd_data, w_s1_data;
  logic            w_s1_err;
  logic [7:0]      w_wr_mask;
  logic [63:0]     w_wr_data, w_window;

  assign req_ready_o = (r_state == ST_IDLE);
  assign dbg_state_o = r_state;
  assign w_accept    = req_valid_i && req_ready_o;
  assign w_illegal   = is_illegal(req_write_i, req_ctrl_i);
  assign w_mis       = !w_illegal && is_misaligned(req_ctrl_i[1:0], req_addr_i[1:0]);
  assign w_err       = w_illegal || (w_mis && (MISALIGN_EN == 0));
  assign w_split     = w_mis && (MISALIGN_EN != 0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept && w_split) w_state_nxt = ST_SPLIT;
      ST_SPLIT: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  data_memory_align u_align (
    .i_wr_off    ((r_state == ST_SPLIT) ? r_off : req_addr_i[1:0]),
    .i_wr_size   ((r_state == ST_SPLIT) ? r_ctrl[1:0] : req_ctrl_i[1:0]),
    .i_wr_data   ((r_state == ST_SPLIT) ? r_wdata : req_wdata_i),
    .o_wr_mask   (w_wr_mask),
    .o_wr_data   (w_wr_data),
    .i_rd_window (w_window),
    .i_rd_off    (r_off),
    .i_rd_ctrl   (r_ctrl),
    .o_rd_data   (w_rd_data)
  );

  // Beat 0 uses the low half of the window, beat 1 the spill into word A+1
  always_comb begin
    w_mem_addr  = req_addr_i[ADDR_WIDTH-1:2];
    w_mem_be    = (w_accept && req_write_i && !w_err) ? w_wr_mask[3:0] : 4'h0;
    w_mem_wdata = w_wr_data[31:0];
    if (r_state == ST_SPLIT) begin
      w_mem_addr  = r_word + 1'b1;
      w_mem_be    = r_write ? w_wr_mask[7:4] : 4'h0;
      w_mem_wdata = w_wr_data[63:32];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (w_mem_be[i]) r_mem[w_mem_addr][i*8 +: 8] <= w_mem_wdata[i*8 +: 8];
    r_rdata <= r_mem[w_mem_addr];
    if (r_state == ST_SPLIT) r_lo <= r_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word     <= '0;
      r_off      <= 2'b00;
      r_ctrl     <= 3'b000;
      r_write    <= 1'b0;
      r_err      <= 1'b0;
      r_split    <= 1'b0;
      r_wdata    <= 32'h0;
      r_s1_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_word  <= req_addr_i[ADDR_WIDTH-1:2];
        r_off   <= req_addr_i[1:0];
        r_ctrl  <= req_ctrl_i;
        r_write <= req_write_i;
        r_err   <= w_err;
        r_split <= w_split;
        r_wdata <= req_wdata_i;
      end
      r_s1_valid <= (w_accept && !w_split) || (r_state == ST_SPLIT);
    end
  end

  assign w_window  = r_split ? {r_rdata, r_lo} : {32'h0, r_rdata};
  assign w_s1_data = (r_s1_valid && !r_write && !r_err) ? w_rd_data : 32'h0;
  assign w_s1_err  = r_s1_valid && r_err;

  if (READ_LATENCY <= 1) begin : g_lat1
    assign rsp_valid_o = r_s1_valid;
    assign rsp_rdata_o = w_s1_data;
    assign rsp_err_o   = w_s1_err;
  end else begin : g_latn
    localparam int NS = READ_LATENCY - 1;
    logic        r_pv [NS];
    logic        r_pe [NS];
    logic [31:0] r_pd [NS];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < NS; i++) begin
          r_pv[i] <= 1'b0;
          r_pe[i] <= 1'b0;
          r_pd[i] <= 32'h0;
        end
      end else begin
        r_pv[0] <= r_s1_valid;
        r_pe[0] <= w_s1_err;
        r_pd[0] <= w_s1_data;
        for (int i = 1; i < NS; i++) begin
          r_pv[i] <= r_pv[i-1];
          r_pe[i] <= r_pe[i-1];
          r_pd[i] <= r_pd[i-1];
        end
      end
    end

    assign rsp_valid_o = r_pv[NS-1];
    assign rsp_rdata_o = r_pd[NS-1];
    assign rsp_err_o   = r_pe[NS-1];
  end

endmodule

// File: tb/tb_data_memory_pipe.sv
// Bench for data_memory_pipe: instance A (latency 2, split enabled) and
// instance B (latency 1, misaligned accesses flagged) against a byte-level model.
module tb_data_memory_pipe;
  import data_memory_pkg::*;

  localparam int LAT_A = 2;
  localparam int LAT_B = 1;

  logic clk, rst;
  logic a_valid, a_ready, a_write, a_rsp_valid, a_err;
  logic [2:0] a_ctrl;
  logic [11:0] a_addr;
  logic [31:0] a_wdata, a_rdata;
  state_t a_dbg;
  logic b_valid, b_ready, b_write, b_rsp_valid, b_err;
  logic [2:0] b_ctrl;
  logic [11:0] b_addr;
  logic [31:0] b_wdata, b_rdata;
  state_t b_dbg;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [31:0] ref_mem [2][1024];
  logic [32:0] exp_q_a[$], exp_q_b[$];
  int exp_c_a[$], exp_c_b[$];
  logic [32:0] mon_e_a, mon_e_b;
  int mon_c_a, mon_c_b;

  data_memory_pipe #(.ADDR_WIDTH(12), .FILE_LOAD(0), .FILE(""), .READ_LATENCY(LAT_A),
                     .MISALIGN_EN(1)) u_dut_a (
    .clk(clk), .rst(rst), .req_valid_i(a_valid), .req_ready_o(a_ready),
    .req_write_i(a_write), .req_ctrl_i(a_ctrl), .req_addr_i(a_addr),
    .req_wdata_i(a_wdata), .rsp_valid_o(a_rsp_valid), .rsp_rdata_o(a_rdata),
    .rsp_err_o(a_err), .dbg_state_o(a_dbg)
  );

  data_memory_pipe #(.ADDR_WIDTH(12), .FILE_LOAD(0), .FILE(""), .READ_LATENCY(LAT_B),
                     .MISALIGN_EN(0)) u_dut_b (
    .clk(clk), .rst(rst), .req_valid_i(b_valid), .req_ready_o(b_ready),
    .req_write_i(b_write), .req_ctrl_i(b_ctrl), .req_addr_i(b_addr),
    .req_wdata_i(b_wdata), .rsp_valid_o(b_rsp_valid), .rsp_rdata_o(b_rdata),
    .rsp_err_o(b_err), .dbg_state_o(b_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // reference model
  function automatic int nbytes(input logic [1:0] sz);
    if (sz == 2'b00) return 1;
    if (sz == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic illegal(input logic wr, input logic [2:0] ctrl);
    if (wr) return ctrl[1:0] == 2'b11;
    return (ctrl == 3'b011) || (ctrl == 3'b110) || (ctrl == 3'b111);
  endfunction

  function automatic logic crosses(input logic [2:0] ctrl, input logic [11:0] addr);
    return (int'(addr[1:0]) + nbytes(ctrl[1:0])) > 4;
  endfunction

  function automatic logic [32:0] model(input int d, input logic wr, input logic [2:0] ctrl,
                                        input logic [11:0] addr, input logic [31:0] wdata);
    int n, a;
    logic [31:0] v;
    if (illegal(wr, ctrl) || (crosses(ctrl, addr) && d == 1)) return {1'b1, 32'h0};
    n = nbytes(ctrl[1:0]);
    v = 32'h0;
    for (int i = 0; i < n; i++) begin
      a = (int'(addr) + i) % 4096;
      if (wr) ref_mem[d][a/4][(a%4)*8 +: 8] = wdata[i*8 +: 8];
      else    v[i*8 +: 8] = ref_mem[d][a/4][(a%4)*8 +: 8];
    end
    if (wr) return 33'h0;
    if (!ctrl[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
    if (!ctrl[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
    return {1'b0, v};
  endfunction

  // driver tasks
  task automatic set_req(input int d, input logic v, input logic wr, input logic [2:0] ctrl,
                         input logic [11:0] addr, input logic [31:0] wdata);
    if (d == 0) begin
      a_valid = v; a_write = wr; a_ctrl = ctrl; a_addr = addr; a_wdata = wdata;
    end else begin
      b_valid = v; b_write = wr; b_ctrl = ctrl; b_addr = addr; b_wdata = wdata;
    end
  endtask

  function automatic logic rdy(input int d);
    return (d == 0) ? a_ready : b_ready;
  endfunction

  task automatic do_req(input int d, input logic wr, input logic [2:0] ctrl,
                        input logic [11:0] addr, input logic [31:0] wdata);
    int budget, lat, acc;
    logic [32:0] e;
    @(negedge clk);
    set_req(d, 1'b1, wr, ctrl, addr, wdata);
    budget = 0;
    while (!rdy(d) && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    if (!rdy(d)) begin
      check_eq("ready_timeout", 0, 1);
      set_req(d, 1'b0, 1'b0, 3'b000, 12'h0, 32'h0);
      return;
    end
    @(posedge clk);
    e = model(d, wr, ctrl, addr, wdata);
    lat = (d == 0) ? LAT_A : LAT_B;
    if (d == 0 && !illegal(wr, ctrl) && crosses(ctrl, addr)) lat++;
    #1;
    acc = cyc;
    if (d == 0) begin exp_q_a.push_back(e); exp_c_a.push_back(acc + lat); end
    else        begin exp_q_b.push_back(e); exp_c_b.push_back(acc + lat); end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 3'b000, 12'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 3'b000, 12'h0, 32'h0);
    repeat (n) @(negedge clk);
  endtask

  // scoreboard monitors: a response seen here is sampled at edge cyc+1
  always @(negedge clk) begin
    if (!rst && a_rsp_valid) begin
      if (exp_q_a.size() == 0) check_eq("a_unexpected_rsp", 1, 0);
      else begin
        mon_e_a = exp_q_a.pop_front();
        mon_c_a = exp_c_a.pop_front();
        check_eq("a_rdata", a_rdata, mon_e_a[31:0]);
        check_eq("a_err", a_err, mon_e_a[32]);
        check_eq("a_latency", cyc + 1, mon_c_a);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_rsp_valid) begin
      if (exp_q_b.size() == 0) check_eq("b_unexpected_rsp", 1, 0);
      else begin
        mon_e_b = exp_q_b.pop_front();
        mon_c_b = exp_c_b.pop_front();
        check_eq("b_rdata", b_rdata, mon_e_b[31:0]);
        check_eq("b_err", b_err, mon_e_b[32]);
        check_eq("b_latency", cyc + 1, mon_c_b);
      end
    end
  end

  initial begin
    logic [2:0] ctrl_tab [8];
    logic [11:0] ad;
    ctrl_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    rst = 1'b0;
    set_req(0, 1'b0, 1'b0, 3'b000, 12'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 3'b000, 12'h0, 32'h0);
    #1 rst = 1'b1;
    #12;
    check_eq("rst_a_valid", a_rsp_valid, 0);
    check_eq("rst_a_rdata", a_rdata, 0);
    check_eq("rst_a_err", a_err, 0);
    check_eq("rst_a_ready", a_ready, 1);
    check_eq("rst_a_state", a_dbg, ST_IDLE);
    check_eq("rst_b_valid", b_rsp_valid, 0);
    check_eq("rst_b_rdata", b_rdata, 0);
    @(negedge clk);
    rst = 1'b0;

    // seed every word the random phase can reach
    for (int w = 0; w <= 20; w++) do_req(0, 1'b1, 3'b010, 12'(w * 4), $urandom);
    for (int w = 1020; w <= 1023; w++) do_req(0, 1'b1, 3'b010, 12'(w * 4), $urandom);
    idle(4);

    do_req(0, 1'b1, 3'b010, 12'h010, 32'hDEADBEEF);
    do_req(0, 1'b0, 3'b010, 12'h010, 32'h0);
    idle(4);

    do_req(0, 1'b1, 3'b010, 12'h020, 32'h44332211);
    do_req(0, 1'b1, 3'b010, 12'h024, 32'h88776655);
    do_req(0, 1'b0, 3'b010, 12'h023, 32'h0);
    check_eq("split_ready_low", a_ready, 0);
    @(posedge clk); #1;
    check_eq("split_ready_back", a_ready, 1);
    idle(4);

    do_req(0, 1'b1, 3'b010, 12'h030, 32'h000080FF);
    do_req(0, 1'b0, 3'b000, 12'h030, 32'h0);
    do_req(0, 1'b0, 3'b100, 12'h030, 32'h0);
    do_req(0, 1'b0, 3'b001, 12'h030, 32'h0);
    do_req(0, 1'b0, 3'b101, 12'h030, 32'h0);
    do_req(0, 1'b1, 3'b000, 12'h031, 32'h000000A5);
    do_req(0, 1'b0, 3'b010, 12'h030, 32'h0);
    idle(4);

    for (int i = 0; i < 8; i++) do_req(0, 1'b0, 3'b010, 12'(i * 4), 32'h0);
    idle(4);

    for (int i = 0; i < 60; i++) begin
      ad = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 'h4F))
                                       : 12'($urandom_range('hFF0, 'hFFF));
      do_req(0, 1'($urandom_range(0, 1)), ctrl_tab[$urandom_range(0, 7)], ad, $urandom);
      if ($urandom_range(0, 3) == 0) idle(0);
    end
    idle(6);

    // reset in the middle of a split store
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 3'b010, 12'h01E, 32'h11223344);
    @(posedge clk); #1;
    check_eq("rst_split_entered", a_dbg, ST_SPLIT);
    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, 3'b000, 12'h0, 32'h0);
    #1;
    check_eq("rst_split_state", a_dbg, ST_IDLE);
    check_eq("rst_split_ready", a_ready, 1);
    check_eq("rst_split_valid", a_rsp_valid, 0);
    ref_mem[0][7][31:16] = 16'h3344;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    do_req(0, 1'b0, 3'b010, 12'h01C, 32'h0);
    do_req(0, 1'b0, 3'b010, 12'h020, 32'h0);
    idle(4);

    // instance B: misaligned accesses are errors
    do_req(1, 1'b1, 3'b010, 12'h010, 32'h12345678);
    do_req(1, 1'b1, 3'b010, 12'h014, 32'h9ABCDEF0);
    do_req(1, 1'b1, 3'b001, 12'h013, 32'h0000BEEF);
    do_req(1, 1'b0, 3'b010, 12'h010, 32'h0);
    do_req(1, 1'b0, 3'b010, 12'h014, 32'h0);
    do_req(1, 1'b0, 3'b011, 12'h010, 32'h0);
    do_req(1, 1'b0, 3'b010, 12'h011, 32'h0);
    do_req(1, 1'b0, 3'b001, 12'h012, 32'h0);
    do_req(1, 1'b1, 3'b111, 12'h014, 32'hFFFFFFFF);
    do_req(1, 1'b0, 3'b010, 12'h014, 32'h0);
    idle(8);

    check_eq("a_drain", exp_q_a.size(), 0);
    check_eq("b_drain", exp_q_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
